// File: rtl/nibble_link_pkg.sv
// Shared types and constants for the forwarded-clock nibble camera link.
// Line packing order matches what the receiver hands to its synchronizer.
package nibble_link_pkg;
  localparam int NIBBLE_W = 4;
  localparam int BYTE_W   = 8;

  // Camera order within a beat group: camera 0 first, then camera 1
  localparam logic CAM0 = 1'b0;
  localparam logic CAM1 = 1'b1;

  // Bit positions of the link lines inside the synchronized vector
  localparam int LN_DATA  = 0;
  localparam int LN_VALID = 4;
  localparam int LN_SOF   = 5;
  localparam int LN_CAM   = 6;
  localparam int LINK_W   = 7;

  typedef enum logic [2:0] {WAIT_SOF, C0_LO, C0_HI, C1_LO, C1_HI} link_rx_state_t;

  function automatic logic expected_cam(link_rx_state_t s);
    return (s == C1_LO || s == C1_HI) ? CAM1 : CAM0;
  endfunction
endpackage

// File: rtl/nibble_link_receiver_if.sv
// Link-side inputs and pixel-pair outputs of the nibble link receiver.
// master = link driver / pixel consumer, slave = receiver.
interface nibble_link_receiver_if;
  import nibble_link_pkg::*;

  logic                link_clk_i;
  logic [NIBBLE_W-1:0] link_data_i;
  logic                link_valid_i;
  logic                link_sof_i;
  logic                link_cam_i;

  logic                pix_valid_o;
  logic [BYTE_W-1:0]   pix0_o;
  logic [BYTE_W-1:0]   pix1_o;
  logic                sof0_o;
  logic                sof1_o;
  logic [15:0]         row_o;
  logic [15:0]         col_o;
  logic                frame_done_o;
  logic [7:0]          err_count_o;

  modport master (
    output link_clk_i, link_data_i, link_valid_i, link_sof_i, link_cam_i,
    input  pix_valid_o, pix0_o, pix1_o, sof0_o, sof1_o, row_o, col_o,
           frame_done_o, err_count_o
  );

  modport slave (
    input  link_clk_i, link_data_i, link_valid_i, link_sof_i, link_cam_i,
    output pix_valid_o, pix0_o, pix1_o, sof0_o, sof1_o, row_o, col_o,
           frame_done_o, err_count_o
  );
endinterface

// File: rtl/nibble_link_receiver_sync_edge.sv
// Synchronizes a forwarded clock plus W companion lines through equal-depth
// flop chains and emits a registered rising-edge strobe with the lines it saw.
module link_sync_edge #(
  parameter int W      = 7,
  parameter int STAGES = 2
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         line_clk_i,
  input  logic [W-1:0] lines_i,
  output logic [W-1:0] lines_o,
  output logic         rise_o
);
  // Forwarded clock rides in the top bit so every line sees the same delay
  logic [STAGES-1:0][W:0] sync_q;
  logic                   clk_prev;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q   <= '0;
      clk_prev <= 1'b0;
      lines_o  <= '0;
      rise_o   <= 1'b0;
    end else begin
      sync_q[0] <= {line_clk_i, lines_i};
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      clk_prev <= sync_q[STAGES-1][W];
      rise_o   <= sync_q[STAGES-1][W] & ~clk_prev;
      lines_o  <= sync_q[STAGES-1][W-1:0];
    end
  end
endmodule

// File: rtl/nibble_link_receiver.sv
// Oversampling receiver for the 4-bit camera link: rebuilds camera-0/1 byte
// pairs, tracks row/col per frame and counts protocol errors.
module nibble_link_receiver
  import nibble_link_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter bit REQUIRE_SOF = 1'b1
) (
  input logic             clk_i,
  input logic             reset_n_i,
  nibble_link_receiver_if.slave lnk
);
  localparam link_rx_state_t IDLE_ST = REQUIRE_SOF ? WAIT_SOF : C0_LO;
  localparam logic [15:0] COL_LAST = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] ROW_LAST = 16'(IMG_HEIGHT - 1);

  logic [LINK_W-1:0]   cap;
  logic                cap_stb;
  logic [NIBBLE_W-1:0] c_data;
  logic                c_valid, c_sof, c_cam;

  link_sync_edge #(.W(LINK_W), .STAGES(SYNC_STAGES)) u_sync (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .line_clk_i (lnk.link_clk_i),
    .lines_i    ({lnk.link_cam_i, lnk.link_sof_i, lnk.link_valid_i, lnk.link_data_i}),
    .lines_o    (cap),
    .rise_o     (cap_stb)
  );

  assign c_data  = cap[LN_DATA +: NIBBLE_W];
  assign c_valid = cap[LN_VALID];
  assign c_sof   = cap[LN_SOF];
  assign c_cam   = cap[LN_CAM];

  link_rx_state_t      state;
  logic                hunt;      // waiting for an sof pair before emitting
  logic [NIBBLE_W-1:0] lo0, lo1;
  logic [BYTE_W-1:0]   byte0;
  logic                s0, s1;
  logic [15:0]         nrow, ncol; // position the next non-sof pair lands on

  logic        exp_cam, mid, f0, f1, any_sof, pair_done, emit, last, err_evt;
  logic [15:0] erow, ecol;

  always_comb begin
    exp_cam   = expected_cam(state);
    mid       = (state == C0_HI) || (state == C1_LO) || (state == C1_HI);
    f0        = s0;
    f1        = s1 | c_sof;
    any_sof   = f0 | f1;
    pair_done = c_valid && (c_cam == exp_cam) && (state == C1_HI);
    // While hunting, a completed pair without sof is silently dropped
    emit      = pair_done && !(hunt && !any_sof);
    erow      = any_sof ? 16'd0 : nrow;
    ecol      = any_sof ? 16'd0 : ncol;
    last      = (erow == ROW_LAST) && (ecol == COL_LAST);
    // Any number of simultaneous faults in one capture costs a single count
    err_evt   = (!c_valid && mid) || (c_valid && (c_cam != exp_cam)) ||
                (emit && ((f0 != f1) || (!hunt && any_sof && (nrow != 16'd0 || ncol != 16'd0))));
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state            <= IDLE_ST;
      hunt             <= REQUIRE_SOF;
      lo0              <= '0;
      lo1              <= '0;
      byte0            <= '0;
      s0               <= 1'b0;
      s1               <= 1'b0;
      nrow             <= '0;
      ncol             <= '0;
      lnk.pix_valid_o  <= 1'b0;
      lnk.pix0_o       <= '0;
      lnk.pix1_o       <= '0;
      lnk.sof0_o       <= 1'b0;
      lnk.sof1_o       <= 1'b0;
      lnk.row_o        <= '0;
      lnk.col_o        <= '0;
      lnk.frame_done_o <= 1'b0;
      lnk.err_count_o  <= '0;
    end else begin
      lnk.pix_valid_o  <= 1'b0;
      lnk.frame_done_o <= 1'b0;
      if (cap_stb) begin
        if (err_evt && lnk.err_count_o != 8'hFF) lnk.err_count_o <= lnk.err_count_o + 8'd1;
        if (!c_valid) begin
          if (mid) begin
            state <= REQUIRE_SOF ? WAIT_SOF : C0_LO;
            hunt  <= hunt | REQUIRE_SOF;
          end
        end else if (c_cam != exp_cam) begin
          if (c_cam == CAM0) begin
            lo0   <= c_data;
            s0    <= c_sof;
            state <= C0_HI;
          end else begin
            state <= hunt ? WAIT_SOF : C0_LO;
          end
        end else begin
          case (state)
            WAIT_SOF, C0_LO: begin lo0 <= c_data; s0 <= c_sof; state <= C0_HI; end
            C0_HI: begin byte0 <= {c_data, lo0}; s0 <= s0 | c_sof; state <= C1_LO; end
            C1_LO: begin lo1 <= c_data; s1 <= c_sof; state <= C1_HI; end
            default: begin
              state <= hunt ? WAIT_SOF : C0_LO;
              if (emit) begin
                lnk.pix_valid_o <= 1'b1;
                lnk.pix0_o      <= byte0;
                lnk.pix1_o      <= {c_data, lo1};
                lnk.sof0_o      <= f0;
                lnk.sof1_o      <= f1;
                lnk.row_o       <= erow;
                lnk.col_o       <= ecol;
                hunt            <= 1'b0;
                state           <= C0_LO;
                if (last) begin
                  lnk.frame_done_o <= 1'b1;
                  nrow <= '0;
                  ncol <= '0;
                  if (REQUIRE_SOF) begin
                    state <= WAIT_SOF;
                    hunt  <= 1'b1;
                  end
                end else if (ecol == COL_LAST) begin
                  ncol <= '0;
                  nrow <= erow + 16'd1;
                end else begin
                  ncol <= ecol + 16'd1;
                  nrow <= erow;
                end
              end
            end
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_nibble_link_receiver.sv
// Self-checking bench: directed scenarios plus randomized groups, checked
// against a queue-based model of pairs, positions and error counts.
module tb_nibble_link_receiver;
  localparam int W = 4;
  localparam int H = 2;
  localparam bit REQ = 1'b1;

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  nibble_link_receiver_if lnk();

  nibble_link_receiver #(.SYNC_STAGES(2), .IMG_WIDTH(W), .IMG_HEIGHT(H), .REQUIRE_SOF(REQ)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .lnk       (lnk)
  );

  typedef struct {
    logic [7:0] p0, p1;
    logic       s0, s1;
    int         row, col;
    logic       done;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] g_data[$];
  logic       g_sof[$];
  bit         m_hunt;
  int         m_pos, m_err;
  int         checks, failures, pulses, dones;
  logic [7:0] last_p0, last_p1;
  logic       last_s0, last_s1;
  int         last_row, last_col;
  exp_t       cx;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  task automatic model_reset();
    exp_q.delete(); g_data.delete(); g_sof.delete();
    m_hunt = REQ; m_pos = 0; m_err = 0;
  endtask

  // Group-level model: a partial group is just a list of accepted nibbles
  task automatic model_capture(input logic v, input logic cam, input logic sof, input logic [3:0] d);
    bit e = 0;
    int n = g_data.size();
    logic f0, f1;
    exp_t x;
    if (!v) begin
      if (n > 0) begin
        e = 1; g_data.delete(); g_sof.delete();
        if (REQ) m_hunt = 1;
      end
    end else if (cam != (n >= 2)) begin
      e = 1; g_data.delete(); g_sof.delete();
      if (cam == 1'b0) begin g_data.push_back(d); g_sof.push_back(sof); end
    end else begin
      g_data.push_back(d); g_sof.push_back(sof);
      if (g_data.size() == 4) begin
        f0 = g_sof[0] | g_sof[1];
        f1 = g_sof[2] | g_sof[3];
        if (!(m_hunt && !(f0 | f1))) begin
          if (f0 != f1) e = 1;
          if (!m_hunt && (f0 | f1) && m_pos != 0) e = 1;
          if (f0 | f1) m_pos = 0;
          x.p0 = {g_data[1], g_data[0]};
          x.p1 = {g_data[3], g_data[2]};
          x.s0 = f0; x.s1 = f1;
          x.row = m_pos / W; x.col = m_pos % W;
          x.done = (m_pos == W * H - 1);
          exp_q.push_back(x);
          m_pos = (m_pos + 1) % (W * H);
          m_hunt = x.done && REQ;
        end
        g_data.delete(); g_sof.delete();
      end
    end
    if (e && m_err < 255) m_err++;
  endtask

  // Sender launches on the falling edge; error count of earlier nibbles is settled by mid-bit
  task automatic send_nibble(input logic cam, input logic [3:0] d, input logic sof, input logic v);
    lnk.link_clk_i = 1'b0; lnk.link_cam_i = cam; lnk.link_data_i = d;
    lnk.link_sof_i = sof; lnk.link_valid_i = v;
    #40;
    chk("err_count", int'(lnk.err_count_o), m_err);
    lnk.link_clk_i = 1'b1;
    model_capture(v, cam, sof, d);
    #40;
  endtask

  task automatic send_pair(input logic [7:0] p0, input logic [7:0] p1, input logic sf0, input logic sf1);
    send_nibble(1'b0, p0[3:0], sf0, 1'b1);
    send_nibble(1'b0, p0[7:4], sf0, 1'b1);
    send_nibble(1'b1, p1[3:0], sf1, 1'b1);
    send_nibble(1'b1, p1[7:4], sf1, 1'b1);
  endtask

  task automatic settle();
    #100;
    chk("pending_pairs", exp_q.size(), 0);
  endtask

  always @(negedge clk_i) begin
    if (lnk.pix_valid_o) begin
      pulses++;
      if (lnk.frame_done_o) dones++;
      last_p0 = lnk.pix0_o; last_p1 = lnk.pix1_o;
      last_s0 = lnk.sof0_o; last_s1 = lnk.sof1_o;
      last_row = int'(lnk.row_o); last_col = int'(lnk.col_o);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pair_unexpected got p0=%h p1=%h with no pair expected", lnk.pix0_o, lnk.pix1_o);
      end else begin
        cx = exp_q.pop_front();
        if (lnk.pix0_o !== cx.p0 || lnk.pix1_o !== cx.p1 || lnk.sof0_o !== cx.s0 ||
            lnk.sof1_o !== cx.s1 || int'(lnk.row_o) != cx.row || int'(lnk.col_o) != cx.col ||
            lnk.frame_done_o !== cx.done) begin
          failures++;
          $display("FAIL pair got p0=%h p1=%h s=%b%b rc=%0d,%0d done=%b expected p0=%h p1=%h s=%b%b rc=%0d,%0d done=%b",
                   lnk.pix0_o, lnk.pix1_o, lnk.sof0_o, lnk.sof1_o, lnk.row_o, lnk.col_o, lnk.frame_done_o,
                   cx.p0, cx.p1, cx.s0, cx.s1, cx.row, cx.col, cx.done);
        end
      end
    end else if (lnk.frame_done_o) begin
      failures++;
      $display("FAIL frame_done_without_valid got=1 expected=0");
    end
  end

  initial begin
    int p, k, mode, sm;
    logic [7:0] a, b;
    logic [3:0] nib[4];
    logic sf[4];
    lnk.link_clk_i = 1'b0; lnk.link_data_i = '0; lnk.link_valid_i = 1'b0;
    lnk.link_sof_i = 1'b0; lnk.link_cam_i = 1'b0;
    checks = 0; failures = 0; pulses = 0; dones = 0;
    last_p0 = '0; last_p1 = '0; last_s0 = 1'b0; last_s1 = 1'b0; last_row = 0; last_col = 0;
    model_reset();

    #23;
    chk("rst_pix_valid", int'(lnk.pix_valid_o), 0);
    chk("rst_pix0", int'(lnk.pix0_o), 0);
    chk("rst_pix1", int'(lnk.pix1_o), 0);
    chk("rst_row", int'(lnk.row_o), 0);
    chk("rst_col", int'(lnk.col_o), 0);
    chk("rst_done", int'(lnk.frame_done_o), 0);
    chk("rst_err", int'(lnk.err_count_o), 0);
    reset_n_i = 1'b1;
    #37;

    // Clean 4x2 frame
    p = pulses;
    for (int i = 0; i < 8; i++) send_pair(8'(8'hA0 + i), 8'(8'h50 + i), i == 0, i == 0);
    settle();
    chk("clean_pulses", pulses - p, 8);
    chk("clean_dones", dones, 1);
    chk("clean_last_p0", int'(last_p0), 'hA7);
    chk("clean_last_row", last_row, 1);
    chk("clean_last_col", last_col, 3);
    chk("clean_err", int'(lnk.err_count_o), 0);

    // Nibble order, then finish that frame
    send_nibble(1'b0, 4'h3, 1'b1, 1'b1);
    send_nibble(1'b0, 4'hC, 1'b1, 1'b1);
    send_nibble(1'b1, 4'h5, 1'b1, 1'b1);
    send_nibble(1'b1, 4'hA, 1'b1, 1'b1);
    settle();
    chk("order_p0", int'(last_p0), 'hC3);
    chk("order_p1", int'(last_p1), 'hA5);
    for (int i = 0; i < 7; i++) send_pair(8'($urandom), 8'($urandom), 1'b0, 1'b0);
    settle();
    chk("second_frame_done", dones, 2);

    // Pairs without sof are discarded while hunting
    p = pulses;
    for (int i = 0; i < 3; i++) send_pair(8'($urandom), 8'($urandom), 1'b0, 1'b0);
    send_pair(8'h11, 8'h22, 1'b1, 1'b1);
    settle();
    chk("hunt_pulses", pulses - p, 1);
    chk("hunt_p0", int'(last_p0), 'h11);
    chk("hunt_row", last_row, 0);
    chk("hunt_col", last_col, 0);
    chk("hunt_err", int'(lnk.err_count_o), 0);

    // valid drops after C0_HI
    send_nibble(1'b0, 4'h1, 1'b0, 1'b1);
    send_nibble(1'b0, 4'h2, 1'b0, 1'b1);
    send_nibble(1'b0, 4'h0, 1'b0, 1'b0);
    send_pair(8'h77, 8'h88, 1'b1, 1'b1);
    settle();
    chk("drop_err", int'(lnk.err_count_o), 1);
    chk("drop_p0", int'(last_p0), 'h77);
    chk("drop_p1", int'(last_p1), 'h88);

    // cam mismatch, then an sof0-only pair mid-frame (one event, one count)
    send_nibble(1'b1, 4'h9, 1'b0, 1'b1);
    send_pair(8'h3C, 8'hC3, 1'b1, 1'b0);
    settle();
    chk("mismatch_err", int'(lnk.err_count_o), 3);
    chk("mismatch_sof0", int'(last_s0), 1);
    chk("mismatch_sof1", int'(last_s1), 0);
    chk("mismatch_col", last_col, 0);

    // Randomized groups with occasional corruption
    for (int g = 0; g < 60; g++) begin
      a = 8'($urandom); b = 8'($urandom);
      sm = $urandom_range(0, 15);
      mode = $urandom_range(0, 7);
      k = $urandom_range(0, 3);
      nib[0] = a[3:0]; nib[1] = a[7:4]; nib[2] = b[3:0]; nib[3] = b[7:4];
      sf[0] = (sm < 2); sf[1] = (sm < 2); sf[2] = (sm == 0); sf[3] = (sm == 0);
      for (int j = 0; j < 4; j++) begin
        if (mode == 0 && j == k) send_nibble(j >= 2, 4'($urandom), 1'b0, 1'b0);
        if (mode == 1 && j == k) send_nibble(!(j >= 2), 4'($urandom), 1'b0, 1'b1);
        send_nibble(j >= 2, nib[j], sf[j], 1'b1);
      end
    end
    settle();

    // Error counter saturation
    for (int i = 0; i < 260; i++) send_nibble(1'b1, 4'h0, 1'b0, 1'b1);
    settle();
    chk("err_saturate", int'(lnk.err_count_o), 255);

    // Async reset between C1_LO and C1_HI
    send_nibble(1'b0, 4'h1, 1'b1, 1'b1);
    send_nibble(1'b0, 4'h2, 1'b1, 1'b1);
    send_nibble(1'b1, 4'h3, 1'b1, 1'b1);
    p = pulses;
    #10 reset_n_i = 1'b0;
    #1;
    model_reset();
    chk("arst_pix_valid", int'(lnk.pix_valid_o), 0);
    chk("arst_pix0", int'(lnk.pix0_o), 0);
    chk("arst_row", int'(lnk.row_o), 0);
    chk("arst_err", int'(lnk.err_count_o), 0);
    lnk.link_clk_i = 1'b0; lnk.link_valid_i = 1'b0;
    #49 reset_n_i = 1'b1;
    #40;
    chk("arst_no_pulse", pulses - p, 0);
    send_pair(8'h5A, 8'hA5, 1'b1, 1'b1);
    settle();
    chk("arst_pulses", pulses - p, 1);
    chk("arst_p0", int'(last_p0), 'h5A);
    chk("arst_p1", int'(last_p1), 'hA5);
    chk("arst_row0", last_row, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
